// File: rtl/morse_char_transmitter.sv
// ----------------------------------------------------------------------------
// morse_char_transmitter
//
// Purpose:
//   Takes one character code per valid/ready handshake and keys it out as
//   Morse code. Elements are timed in units of UNIT_CYCLES clocks:
//     - dit mark: 1 unit
//     - dah mark: 3 units
//     - gap between elements of a character: 1 unit
//     - gap after a character: 3 units
//   Any code that is not a letter is sent as 4 silent units. Added to the
//   3-unit gap after the previous letter, this gives the 7-unit word gap.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   char_in     in   character code (CHAR_CODE_A..CHAR_CODE_F, CHAR_CODE_SPACE)
//   char_valid  in   char_in is valid
//   char_ready  out  a character is accepted on this cycle's edge if valid
//   key_out     out  registered key: 1 = mark (tone on), 0 = silence
//   busy        out  inverse of char_ready
// ----------------------------------------------------------------------------
module morse_char_transmitter #(
    parameter int  UNIT_CYCLES = 4,
    localparam int CHAR_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              key_out,
    output logic              busy
);

    // Character set and pattern geometry shared with the Morse recognizer.
    localparam logic [CHAR_W-1:0] CHAR_CODE_A     = 3'd0;
    localparam logic [CHAR_W-1:0] CHAR_CODE_B     = 3'd1;
    localparam logic [CHAR_W-1:0] CHAR_CODE_C     = 3'd2;
    localparam logic [CHAR_W-1:0] CHAR_CODE_D     = 3'd3;
    localparam logic [CHAR_W-1:0] CHAR_CODE_E     = 3'd4;
    localparam logic [CHAR_W-1:0] CHAR_CODE_F     = 3'd5;
    localparam logic [CHAR_W-1:0] CHAR_CODE_SPACE = 3'd6;

    localparam int MORSE_LEN_W   = 3;
    localparam int MAX_MORSE_LEN = 4;
    // The stored pattern is widened so that any element index value
    // selects a real bit.
    localparam int PAT_W         = 1 << MORSE_LEN_W;

    // The duration counter holds (cycles remaining - 1) in the current state.
    localparam int CNT_W = $clog2(4 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DIT_LD        = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAH_LD        = CNT_W'(3 * UNIT_CYCLES - 1);
    // GAP lasts one cycle less than the full gap. The IDLE cycle that
    // follows supplies the last silent cycle.
    localparam logic [CNT_W-1:0] LETTER_GAP_LD = CNT_W'(3 * UNIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] SPACE_GAP_LD  = CNT_W'(4 * UNIT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        ISPACE,
        GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MORSE_LEN_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0]       pat_q, pat_d;
    logic                   key_q;

    logic [MORSE_LEN_W-1:0]   lk_len;
    logic [MAX_MORSE_LEN-1:0] lk_pat;
    logic [PAT_W-1:0]         lk_pat_ext;

    function automatic logic [CNT_W-1:0] mark_load(input logic dah);
        return dah ? DAH_LD : DIT_LD;
    endfunction

    // Pattern lookup: bit 1 = dah, 0 = dit, sent from bit len-1 down to 0.
    // A length of 0 marks a word space.
    always_comb begin
        lk_len = '0;
        lk_pat = '0;
        case (char_in)
            CHAR_CODE_A: begin lk_len = 3'd2; lk_pat = 4'b0001; end
            CHAR_CODE_B: begin lk_len = 3'd4; lk_pat = 4'b1000; end
            CHAR_CODE_C: begin lk_len = 3'd4; lk_pat = 4'b1010; end
            CHAR_CODE_D: begin lk_len = 3'd3; lk_pat = 4'b0100; end
            CHAR_CODE_E: begin lk_len = 3'd1; lk_pat = 4'b0000; end
            CHAR_CODE_F: begin lk_len = 3'd4; lk_pat = 4'b0010; end
            CHAR_CODE_SPACE: begin lk_len = '0; lk_pat = '0; end
            default:     begin lk_len = '0; lk_pat = '0; end
        endcase
    end

    assign lk_pat_ext = {{(PAT_W - MAX_MORSE_LEN){1'b0}}, lk_pat};

    // NOTE: every signal written in this block receives a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    pat_d = lk_pat_ext;
                    if (lk_len == '0) begin
                        state_d = GAP;
                        cnt_d   = SPACE_GAP_LD;
                        idx_d   = '0;
                    end else begin
                        state_d = MARK;
                        idx_d   = lk_len - 1'b1;
                        cnt_d   = mark_load(lk_pat_ext[idx_d]);
                    end
                end
            end

            MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == '0) begin
                    state_d = GAP;
                    cnt_d   = LETTER_GAP_LD;
                end else begin
                    state_d = ISPACE;
                    cnt_d   = DIT_LD;
                end
            end

            ISPACE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = MARK;
                    idx_d   = idx_q - 1'b1;
                    cnt_d   = mark_load(pat_q[idx_d]);
                end
            end

            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the pre-edge values and there are no ordering races between blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the pattern register is reset along with the control
            // state. It is only a few flops, and this keeps it from showing X.
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            // The key comes from a flop so that it changes only with the state.
            key_q   <= (state_d == MARK);
        end
    end

    assign char_ready = (state_q == IDLE);
    assign busy       = ~char_ready;
    assign key_out    = key_q;

endmodule

// File: doc/morse_char_transmitter.md
# morse_char_transmitter

Converts one character code per handshake into a keyed on/off Morse signal with standard unit timing: dit 1 unit, dah 3 units, 1-unit intra-character gap, 3-unit inter-character gap, 7-unit word gap. It is the transmit-side counterpart of the Morse character recognizer. It uses the same `CHAR_CODE_*` set and the same pattern encoding (`len`, `dits_dahs`) from `defines.vh`. Upstream logic feeds characters through a valid/ready handshake, and `key_out` drives the tone/LED keyer.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse unit; must be ≥ 1.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `char_in`  in  `CHAR_W`: character code (`CHAR_CODE_A`..`CHAR_CODE_F`, `CHAR_CODE_SPACE`).
- `char_valid`  in  1: `char_in` is valid.
- `char_ready`  out  1: block accepts a character this cycle.
- `key_out`  out  1: 1 = mark (tone on), 0 = silence; registered.
- `busy`  out  1: equals `!char_ready`.

## Operation
- Pattern lookup is internal and combinational. It produces `len` (`MORSE_LEN_W` bits) and `dits_dahs` (`MAX_MORSE_LEN` bits).
- Elements are sent from bit `len-1` down to bit 0. A bit value of 1 is a dah; 0 is a dit.
- Letter patterns:
  - A: len 2, 01
  - B: len 4, 1000
  - C: len 4, 1010
  - D: len 3, 100
  - E: len 1, 0
  - F: len 4, 0010
- Any other code, including `CHAR_CODE_SPACE`, is treated as a word space: no marks, 4 units of silence. Together with the previous character's 3-unit gap this yields the 7-unit word gap.
- Transfer occurs on a rising edge where `char_valid && char_ready`. On that edge the block latches the pattern, the length, and the element index (`len-1`).
- FSM states:
  - IDLE: `char_ready`=1, `key_out`=0. On transfer, go to MARK for a letter or to GAP for a space. GAP length is set to 4U-1 for a space.
  - MARK: `key_out`=1 for U cycles (dit) or 3U cycles (dah). At the end, if the index is 0, go to GAP with length 3U-1. Otherwise go to ISPACE.
  - ISPACE: `key_out`=0 for U cycles; decrement the index; go to MARK.
  - GAP: `key_out`=0 for the loaded length; then go to IDLE. The IDLE cycle supplies the final gap cycle, so the gap is exact under back-to-back transfer.
- Counters:
  - Unit/duration counter: down-counter wide enough for 4U-1, i.e. `$clog2(4*UNIT_CYCLES)` bits minimum.
  - Element index: `MORSE_LEN_W` bits.
  - Neither counter wraps; each is reloaded at every state entry.
- `char_valid` is ignored while not ready. `char_in` is sampled only at transfer and need not be held afterwards.
- Reset behaviour:
  - Reset asserted at any point, including mid-character, aborts the character.
  - After the reset edge: state IDLE, `key_out`=0, `char_ready`=1, `busy`=0, counters 0.
  - Reset has priority over a simultaneous transfer; the offered character is not accepted.

## Timing
- U = `UNIT_CYCLES`. Cycle 0 is the transfer edge. Relative cycle n means the nth cycle after it.
- Letter: `key_out` rises at cycle 1, i.e. one cycle after transfer.
- Total character period P:
  - Letter: P = (sum of element units + (len-1) + 3)·U.
  - Space: P = 4U.
- `char_ready` is high again at cycle P. A transfer at cycle P starts the next mark at cycle P+1, giving exactly 3U silent cycles after the last mark.
- `key_out` never glitches: it is a flop output that changes only on state transitions.
- With `char_valid` held high, throughput is one character per P cycles with no idle cycles.

## Test plan
- Reset, then E with U=4:
  - `key_out`=1 at cycles 1–4 and 0 at cycles 5–16.
  - `char_ready`=0 at cycles 1–15 and 1 at cycle 16.
- A with U=4:
  - `key_out` high at cycles 1–4, low 5–8, high 9–20, low 21–32.
  - `char_ready` returns at cycle 32.
- C then D back-to-back, `char_valid` held high, U=2:
  - C marks: 6,2,6,2 high-cycles, with 2-cycle gaps between.
  - Exactly 6 silent cycles between C's last mark and D's first mark.
  - D marks: 6,2,2.
  - Second transfer occurs at cycle 28.
- `CHAR_CODE_SPACE`, and separately an unmapped code, with U=4:
  - `key_out` stays 0 throughout.
  - `char_ready` returns at cycle 16.
- Reset asserted during the second element of B:
  - After the reset edge, `key_out`=0 and `char_ready`=1.
  - A new E then sends exactly one 4-cycle mark.
- `char_valid` pulsed while busy (char F):
  - The offered character is ignored.
  - Only the original character's pattern appears on `key_out`.
